// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared key definitions and integrator step decision
package key_debounce_pkg;

   localparam int NKEYS_DEF = 13;

   // Bit positions in the keys vector, shared with the SFR and firmware
   typedef enum logic [3:0] {
      KEY0 = 4'd0,  KEY1 = 4'd1,  KEY2 = 4'd2,  KEY3 = 4'd3,
      SW0  = 4'd4,  SW1  = 4'd5,  SW2  = 4'd6,  SW3  = 4'd7,
      SW4  = 4'd8,  SW5  = 4'd9,  SW6  = 4'd10, SW7  = 4'd11,
      SW8  = 4'd12
   } key_idx_e;

   typedef enum logic [1:0] {
      INTEG_HOLD = 2'd0,
      INTEG_UP   = 2'd1,
      INTEG_DOWN = 2'd2
   } integ_op_e;

   // Saturating step: never count past either end of the integrator range
   function automatic integ_op_e integ_op(input logic s, input logic at_max, input logic at_min);
      if (s && !at_max) return INTEG_UP;
      if (!s && !at_min) return INTEG_DOWN;
      return INTEG_HOLD;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - per-key hysteresis integrator with registered press/release pulses
module debounce_cell
   import key_debounce_pkg::*;
#(
   parameter int CNT_W   = 3,
   parameter int DEB_MAX = 7
) (
   input  logic clk,
   input  logic nreset,
   input  logic i_tick,
   input  logic i_s,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_press_nxt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_MAX);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_level;
   logic             w_level_nxt;
   logic             r_press;
   logic             r_release;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_tick) begin
         case (integ_op(i_s, r_cnt == CNT_MAX, r_cnt == '0))
            INTEG_UP:   w_cnt_nxt = r_cnt + CNT_W'(1);
            INTEG_DOWN: w_cnt_nxt = r_cnt - CNT_W'(1);
            default:    w_cnt_nxt = r_cnt;
         endcase
      end
   end

   // Level flips only at the integrator ends, holding anywhere in between
   always_comb begin
      w_level_nxt = r_level;
      if (i_tick) begin
         if (w_cnt_nxt == CNT_MAX) begin
            w_level_nxt = 1'b1;
         end else if (w_cnt_nxt == '0) begin
            w_level_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_level_nxt & ~r_level;
         r_release <= ~w_level_nxt & r_level;
      end
   end

   assign o_level     = r_level;
   assign o_press     = r_press;
   assign o_release   = r_release;
   assign o_press_nxt = w_level_nxt & ~r_level;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronises and debounces board keys, emits level and event pulses
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int NKEYS      = NKEYS_DEF,
   parameter int PRESC      = 50000,
   parameter int PRESC_W    = 16,
   parameter int DEB_MAX    = 7,
   parameter int CNT_W      = 3,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [NKEYS-1:0] keys_raw,
   output logic [NKEYS-1:0] keys,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic             key_any
);

   localparam logic [NKEYS-1:0]   INACTIVE   = {NKEYS{1'(ACTIVE_LOW != 0)}};
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);

   logic [NKEYS-1:0]   r_sync1;
   logic [NKEYS-1:0]   r_sync2;
   logic [NKEYS-1:0]   w_s;
   logic [PRESC_W-1:0] r_presc;
   logic               w_tick;
   logic [NKEYS-1:0]   w_press_nxt;
   logic               r_any;

   // Reset to the idle pin level so reset never looks like a press
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_sync1 <= INACTIVE;
         r_sync2 <= INACTIVE;
      end else begin
         r_sync1 <= keys_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2 ^ INACTIVE;

   // With PRESC=1 the counter sits at 0 and the tick is permanently high
   assign w_tick = (r_presc == PRESC_LAST);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PRESC_W'(1);
      end
   end

   for (genvar gi = 0; gi < NKEYS; gi++) begin : g_cell
      debounce_cell #(
         .CNT_W   (CNT_W),
         .DEB_MAX (DEB_MAX)
      ) u_cell (
         .clk         (clk),
         .nreset      (nreset),
         .i_tick      (w_tick),
         .i_s         (w_s[gi]),
         .o_level     (keys[gi]),
         .o_press     (key_press[gi]),
         .o_release   (key_release[gi]),
         .o_press_nxt (w_press_nxt[gi])
      );
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_any <= 1'b0;
      end else begin
         r_any <= |w_press_nxt;
      end
   end

   assign key_any = r_any;

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - randomized and directed bench against a per-tick reference model
module tb_key_debounce;
   import key_debounce_pkg::*;

   localparam int NK  = 13;
   localparam int DEB = 3;

   logic          clk = 1'b0;
   logic          nrst_a, nrst_b;
   logic [NK-1:0] raw_a, raw_b;
   logic [NK-1:0] keys_a, press_a, rel_a;
   logic [NK-1:0] keys_b, press_b, rel_b;
   logic          any_a, any_b;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 0;

   always #5 clk = ~clk;

   key_debounce #(.NKEYS(NK), .PRESC(4), .PRESC_W(3), .DEB_MAX(DEB), .CNT_W(2), .ACTIVE_LOW(1)) dut_a (
      .clk(clk), .nreset(nrst_a), .keys_raw(raw_a), .keys(keys_a),
      .key_press(press_a), .key_release(rel_a), .key_any(any_a));

   key_debounce #(.NKEYS(NK), .PRESC(1), .PRESC_W(1), .DEB_MAX(DEB), .CNT_W(2), .ACTIVE_LOW(0)) dut_b (
      .clk(clk), .nreset(nrst_b), .keys_raw(raw_b), .keys(keys_b),
      .key_press(press_b), .key_release(rel_b), .key_any(any_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: s is the pin seen two edges ago, ticks every PRESC edges since reset
   function automatic int presc_of(input int u);
      return (u == 0) ? 4 : 1;
   endfunction

   function automatic bit active_low_of(input int u);
      return (u == 0);
   endfunction

   int            m_edges [2];
   int            m_cnt   [2][NK];
   logic          m_p1    [2][NK];
   logic          m_p2    [2][NK];
   logic [NK-1:0] m_lvl   [2];
   logic [NK-1:0] m_press [2];
   logic [NK-1:0] m_rel   [2];

   task automatic model_reset(input int u);
      m_edges[u] = 0;
      for (int i = 0; i < NK; i++) begin
         m_cnt[u][i] = 0;
         m_p1[u][i]  = 1'b0;
         m_p2[u][i]  = 1'b0;
      end
      m_lvl[u]   = '0;
      m_press[u] = '0;
      m_rel[u]   = '0;
   endtask

   task automatic model_step(input int u, input logic [NK-1:0] raw);
      bit            tick;
      logic          s;
      logic [NK-1:0] old;
      tick = ((m_edges[u] % presc_of(u)) == presc_of(u) - 1);
      m_edges[u]++;
      old = m_lvl[u];
      for (int i = 0; i < NK; i++) begin
         s = m_p2[u][i];
         m_p2[u][i] = m_p1[u][i];
         m_p1[u][i] = active_low_of(u) ? ~raw[i] : raw[i];
         if (tick) begin
            if (s) m_cnt[u][i] = (m_cnt[u][i] + 1 > DEB) ? DEB : m_cnt[u][i] + 1;
            else   m_cnt[u][i] = (m_cnt[u][i] - 1 < 0) ? 0 : m_cnt[u][i] - 1;
            if (m_cnt[u][i] == DEB)    m_lvl[u][i] = 1'b1;
            else if (m_cnt[u][i] == 0) m_lvl[u][i] = 1'b0;
         end
      end
      m_press[u] = m_lvl[u] & ~old;
      m_rel[u]   = ~m_lvl[u] & old;
   endtask

   always @(posedge clk or negedge nrst_a) begin
      if (!nrst_a) model_reset(0);
      else         model_step(0, raw_a);
   end

   always @(posedge clk or negedge nrst_b) begin
      if (!nrst_b) model_reset(1);
      else         model_step(1, raw_b);
   end

   int cnt_press_a [NK];
   int cnt_rel_a   [NK];
   int cnt_any_a = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mdl_keys_a",  keys_a,  m_lvl[0]);
         chk("mdl_press_a", press_a, m_press[0]);
         chk("mdl_rel_a",   rel_a,   m_rel[0]);
         chk("mdl_any_a",   any_a,   (m_press[0] != '0));
         chk("mdl_keys_b",  keys_b,  m_lvl[1]);
         chk("mdl_press_b", press_b, m_press[1]);
         chk("mdl_rel_b",   rel_b,   m_rel[1]);
         chk("mdl_any_b",   any_b,   (m_press[1] != '0));
         chk("excl_a",      press_a & rel_a, 0);
         for (int i = 0; i < NK; i++) begin
            cnt_press_a[i] += int'(press_a[i]);
            cnt_rel_a[i]   += int'(rel_a[i]);
         end
         cnt_any_a += int'(any_a);
      end
   end

   task automatic drive_point();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_key(input int u, input int idx, input logic val, input int maxc, output bit ok);
      int cyc;
      cyc = 0;
      ok  = 0;
      while (!ok && cyc < maxc) begin
         @(negedge clk);
         cyc++;
         if (((u == 0) ? keys_a[idx] : keys_b[idx]) == val) ok = 1;
      end
   endtask

   initial begin
      bit ok;
      int p0, r0, a0;
      for (int i = 0; i < NK; i++) begin
         cnt_press_a[i] = 0;
         cnt_rel_a[i]   = 0;
      end
      nrst_a = 1'b1;
      nrst_b = 1'b1;
      raw_a  = '1;
      raw_b  = '0;
      #2;
      nrst_a = 1'b0;
      nrst_b = 1'b0;
      cmp_en = 1;

      repeat (5) @(negedge clk);
      chk("rst_keys",  keys_a,  0);
      chk("rst_press", press_a, 0);
      chk("rst_any",   any_a,   0);
      drive_point();
      nrst_a = 1'b1;
      nrst_b = 1'b1;
      repeat (100) @(negedge clk);
      chk("idle_keys", keys_a, 0);

      // Clean press/release on KEY0: bound 2 + 3*4 + 4, plus the drive-point offset
      drive_point();
      raw_a[KEY0] = 1'b0;
      wait_key(0, int'(KEY0), 1'b1, 19, ok);
      chk("press_lat", ok, 1);
      chk("press0",    press_a, 13'h0001);
      chk("any0",      any_a, 1);
      @(negedge clk);
      chk("press0_one", press_a, 0);
      drive_point();
      raw_a[KEY0] = 1'b1;
      wait_key(0, int'(KEY0), 1'b0, 19, ok);
      chk("rel_lat", ok, 1);
      chk("rel0",    rel_a, 13'h0001);
      chk("rel0_np", press_a, 0);

      // Bounce on SW1 (bit 5): flip once per tick for 40 clk
      p0 = cnt_press_a[5];
      r0 = cnt_rel_a[5];
      for (int k = 0; k < 10; k++) begin
         drive_point();
         raw_a[SW1] = ~raw_a[SW1];
         repeat (3) @(posedge clk);
      end
      repeat (30) @(negedge clk);
      chk("bounce_lvl",   keys_a[5], 0);
      chk("bounce_press", cnt_press_a[5] - p0, 0);
      chk("bounce_rel",   cnt_rel_a[5] - r0, 0);

      // Simultaneous press of KEY3 and SW8
      a0 = cnt_any_a;
      drive_point();
      raw_a[KEY3] = 1'b0;
      raw_a[SW8]  = 1'b0;
      wait_key(0, 3, 1'b1, 19, ok);
      chk("simul_lat",   ok, 1);
      chk("simul_k12",   keys_a[12], 1);
      chk("simul_press", press_a, 13'h1008);
      chk("simul_any",   any_a, 1);
      repeat (5) @(negedge clk);
      chk("simul_any_once", cnt_any_a - a0, 1);
      drive_point();
      raw_a[KEY3] = 1'b1;
      raw_a[SW8]  = 1'b1;
      wait_key(0, 3, 1'b0, 19, ok);
      chk("simul_rel_lat", ok, 1);
      chk("simul_rel",     rel_a, 13'h1008);

      // Reset while SW3 (bit 7) is held
      drive_point();
      raw_a[SW3] = 1'b0;
      wait_key(0, 7, 1'b1, 19, ok);
      chk("mid_lat", ok, 1);
      @(negedge clk);
      p0 = cnt_press_a[7];
      r0 = cnt_rel_a[7];
      drive_point();
      nrst_a = 1'b0;
      @(negedge clk);
      chk("mid_keys0", keys_a, 0);
      chk("mid_rel0",  rel_a,  0);
      drive_point();
      nrst_a = 1'b1;
      wait_key(0, 7, 1'b1, 19, ok);
      chk("mid_requal", ok, 1);
      @(negedge clk);
      chk("mid_norel",   cnt_rel_a[7] - r0, 0);
      chk("mid_onepress", cnt_press_a[7] - p0, 1);
      drive_point();
      raw_a[SW3] = 1'b1;
      wait_key(0, 7, 1'b0, 19, ok);
      chk("mid_rel_lat", ok, 1);

      // PRESC=1, active-high: exact 2+3 clk latency both ways, after saturation
      drive_point();
      raw_b[KEY1] = 1'b1;
      repeat (5) @(negedge clk);
      chk("b_rise_early", keys_b[1], 0);
      @(negedge clk);
      chk("b_rise",  keys_b[1], 1);
      chk("b_press", press_b, 13'h0002);
      repeat (50) @(posedge clk);
      drive_point();
      raw_b[KEY1] = 1'b0;
      repeat (5) @(negedge clk);
      chk("b_fall_early", keys_b[1], 1);
      @(negedge clk);
      chk("b_fall", keys_b[1], 0);
      chk("b_rel",  rel_b, 13'h0002);

      // Random pin activity, occasional bounce bursts and resets, model checked every clk
      for (int c = 0; c < 4000; c++) begin
         drive_point();
         if ($urandom_range(0, 15) == 0) raw_a[$urandom_range(0, NK - 1)] ^= 1'b1;
         if ($urandom_range(0, 15) == 0) raw_b[$urandom_range(0, NK - 1)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0) raw_a[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 63) == 0) raw_b[$urandom_range(0, 3)] ^= 1'b1;
         nrst_a = ($urandom_range(0, 599) != 0);
         nrst_b = ($urandom_range(0, 599) != 0);
      end
      drive_point();
      nrst_a = 1'b1;
      nrst_b = 1'b1;
      repeat (20) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
